axi_burst_addr_gen: RTL and testbench



---
 rtl/params_pkg.sv | 31 +++
 rtl/axi_next_addr.sv | 51 +++++
 rtl/axi_burst_addr_gen.sv | 184 ++++++++++++++++++
 tb/tb_axi_burst_addr_gen.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/params_pkg.sv
`default_nettype none
// ============================================================================
// Module      : params_pkg
// Description : Shared AXI parameters and types for the burst address path.
//               AXI_*_WIDTH : default bus field widths
//               axi_burst_t : AXI burst type encoding (FIXED/INCR/WRAP/RSVD)
//               burst_fsm_t : state encoding of the burst address generator
// Revision    : 1.0 - initial release
// ============================================================================
package params_pkg;

    localparam int AXI_ADDR_WIDTH = 64;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_LEN_WIDTH  = 8;
    localparam int AXI_ID_WIDTH   = 6;
    localparam int AXI_SIZE_WIDTH = 3;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } axi_burst_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_fsm_t;

endpackage : params_pkg
`default_nettype wire

// File: rtl/axi_next_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_next_addr
// Description : Combinational AXI next-beat address calculator, shared by
//               the read and write address paths.
// Ports       : i_addr      - current beat address
//               i_size      - beat size (log2 bytes), already legal for the bus
//               i_len       - burst length minus one
//               i_burst     - burst type (RSVD treated as INCR)
//               o_next_addr - address of the following beat
// Revision    : 1.0 - initial release
// ============================================================================
module axi_next_addr
    import params_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = params_pkg::AXI_ADDR_WIDTH,
    parameter int C_AXI_LEN_WIDTH  = params_pkg::AXI_LEN_WIDTH
) (
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_addr,
    input  logic [AXI_SIZE_WIDTH-1:0]   i_size,
    input  logic [C_AXI_LEN_WIDTH-1:0]  i_len,
    input  logic [1:0]                  i_burst,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_next_addr
);

    logic [C_AXI_ADDR_WIDTH-1:0] w_beat_bytes;
    logic [C_AXI_ADDR_WIDTH-1:0] w_aligned;
    logic [C_AXI_ADDR_WIDTH-1:0] w_incr;
    logic [C_AXI_ADDR_WIDTH-1:0] w_window_mask;
    logic [C_AXI_ADDR_WIDTH-1:0] w_wrapped;

    assign w_beat_bytes  = C_AXI_ADDR_WIDTH'(1) << i_size;
    assign w_aligned     = i_addr & ~(w_beat_bytes - C_AXI_ADDR_WIDTH'(1));
    assign w_incr        = w_aligned + w_beat_bytes;
    // Wrap window is (len+1) beats; the caller guarantees len+1 is a power of two.
    assign w_window_mask = ((C_AXI_ADDR_WIDTH'(i_len) + C_AXI_ADDR_WIDTH'(1)) << i_size)
                           - C_AXI_ADDR_WIDTH'(1);
    // Keep the window base, take the offset from the incremented address.
    assign w_wrapped     = (i_addr & ~w_window_mask) | (w_incr & w_window_mask);

    always_comb begin
        o_next_addr = w_incr;
        case (axi_burst_t'(i_burst))
            FIXED:   o_next_addr = i_addr;
            WRAP:    o_next_addr = w_wrapped;
            default: o_next_addr = w_incr;
        endcase
    end

endmodule : axi_next_addr
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr_gen
// Description : Accepts one AXI burst command and emits one address per beat
//               with a valid/ready handshake. Illegal size, reserved burst
//               type and illegal WRAP length are repaired (clamped / treated
//               as INCR) and flagged on o_err for every beat of the burst.
// Config      : AXI_BURST_4K_CHECK_EN - when defined, INCR bursts whose last
//               byte lies in a different 4 KiB page than the start address
//               also raise o_err.
// Ports       : i_clk, i_reset      - clock, synchronous active-high reset
//               i_cmd_*/o_cmd_ready - command channel
//               o_beat_*/i_beat_ready - per-beat address channel
//               o_err               - burst-level error flag (valid with beat)
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import params_pkg::*;
#(
    parameter int C_AXI_ADDR_WIDTH = params_pkg::AXI_ADDR_WIDTH,
    parameter int C_AXI_DATA_WIDTH = params_pkg::AXI_DATA_WIDTH,
    parameter int C_AXI_LEN_WIDTH  = params_pkg::AXI_LEN_WIDTH,
    parameter int C_AXI_ID_WIDTH   = params_pkg::AXI_ID_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic [C_AXI_ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [C_AXI_LEN_WIDTH-1:0]  i_cmd_len,
    input  logic [AXI_SIZE_WIDTH-1:0]   i_cmd_size,
    input  logic [1:0]                  i_cmd_burst,
    input  logic [C_AXI_ID_WIDTH-1:0]   i_cmd_id,
    output logic                        o_beat_valid,
    input  logic                        i_beat_ready,
    output logic [C_AXI_ADDR_WIDTH-1:0] o_beat_addr,
    output logic [C_AXI_ID_WIDTH-1:0]   o_beat_id,
    output logic [C_AXI_LEN_WIDTH-1:0]  o_beat_idx,
    output logic                        o_beat_last,
    output logic                        o_err
);

    localparam logic [AXI_SIZE_WIDTH-1:0] c_max_size =
        AXI_SIZE_WIDTH'($clog2(C_AXI_DATA_WIDTH / 8));

    burst_fsm_t                  r_state;
    burst_fsm_t                  w_next_state;
    logic [C_AXI_ADDR_WIDTH-1:0] r_addr;
    logic [C_AXI_LEN_WIDTH-1:0]  r_len;
    logic [C_AXI_LEN_WIDTH-1:0]  r_idx;
    logic [AXI_SIZE_WIDTH-1:0]   r_size;
    axi_burst_t                  r_burst;
    logic [C_AXI_ID_WIDTH-1:0]   r_id;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_last;
    logic                        w_size_bad;
    logic                        w_wrap_len_ok;
    logic [AXI_SIZE_WIDTH-1:0]   w_size_eff;
    axi_burst_t                  w_burst_eff;
    logic                        w_err_cmd;
    logic                        w_cross_4k;
    logic [C_AXI_ADDR_WIDTH-1:0] w_next_addr;

    // ------------------------------------------------------------------
    // Command decode: repair illegal fields before latching them
    // ------------------------------------------------------------------
    assign w_size_bad    = (i_cmd_size > c_max_size);
    assign w_size_eff    = w_size_bad ? c_max_size : i_cmd_size;
    assign w_wrap_len_ok = (i_cmd_len == C_AXI_LEN_WIDTH'(1))
                        || (i_cmd_len == C_AXI_LEN_WIDTH'(3))
                        || (i_cmd_len == C_AXI_LEN_WIDTH'(7))
                        || (i_cmd_len == C_AXI_LEN_WIDTH'(15));

    always_comb begin
        w_burst_eff = axi_burst_t'(i_cmd_burst);
        w_err_cmd   = w_size_bad;
        if (axi_burst_t'(i_cmd_burst) == RSVD) begin
            w_burst_eff = INCR;
            w_err_cmd   = 1'b1;
        end else if ((axi_burst_t'(i_cmd_burst) == WRAP) && !w_wrap_len_ok) begin
            w_burst_eff = INCR;
            w_err_cmd   = 1'b1;
        end
    end

`ifdef AXI_BURST_4K_CHECK_EN
    logic [C_AXI_ADDR_WIDTH-1:0] w_bytes_4k;
    logic [C_AXI_ADDR_WIDTH-1:0] w_last_byte;
    logic [C_AXI_ADDR_WIDTH-1:0] w_page_diff;

    assign w_bytes_4k  = C_AXI_ADDR_WIDTH'(1) << w_size_eff;
    assign w_last_byte = (i_cmd_addr & ~(w_bytes_4k - C_AXI_ADDR_WIDTH'(1)))
                       + ((C_AXI_ADDR_WIDTH'(i_cmd_len) + C_AXI_ADDR_WIDTH'(1)) << w_size_eff)
                       - C_AXI_ADDR_WIDTH'(1);
    // Any differing bit at or above bit 12 means a different 4 KiB page.
    assign w_page_diff = (w_last_byte ^ i_cmd_addr) >> 12;
    assign w_cross_4k  = (w_burst_eff == INCR) && (w_page_diff != '0);
`else
    assign w_cross_4k  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_cmd_ready  = 1'b0;
        o_beat_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_cmd_ready = !i_reset;
                if (i_cmd_valid) begin
                    w_next_state = BURST;
                end
            end
            BURST: begin
                o_beat_valid = !i_reset;
                if (i_beat_ready && w_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_accept = i_cmd_valid && (r_state == IDLE);
    assign w_last   = (r_idx == r_len);

    // ------------------------------------------------------------------
    // Burst datapath
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_size  <= '0;
            r_burst <= FIXED;
            r_id    <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= i_cmd_addr;
            r_len   <= i_cmd_len;
            r_idx   <= '0;
            r_size  <= w_size_eff;
            r_burst <= w_burst_eff;
            r_id    <= i_cmd_id;
            r_err   <= w_err_cmd | w_cross_4k;
        end else if ((r_state == BURST) && i_beat_ready && !w_last) begin
            r_addr  <= w_next_addr;
            r_idx   <= r_idx + C_AXI_LEN_WIDTH'(1);
        end
    end

    axi_next_addr #(
        .C_AXI_ADDR_WIDTH (C_AXI_ADDR_WIDTH),
        .C_AXI_LEN_WIDTH  (C_AXI_LEN_WIDTH)
    ) u_next_addr (
        .i_addr      (r_addr),
        .i_size      (r_size),
        .i_len       (r_len),
        .i_burst     (r_burst),
        .o_next_addr (w_next_addr)
    );

    // Beat fields read as zero whenever no beat is offered (including reset).
    assign o_beat_addr = o_beat_valid ? r_addr : '0;
    assign o_beat_id   = o_beat_valid ? r_id   : '0;
    assign o_beat_idx  = o_beat_valid ? r_idx  : '0;
    assign o_beat_last = o_beat_valid && w_last;
    assign o_err       = o_beat_valid && r_err;

endmodule : axi_burst_addr_gen
`default_nettype wire

// File: tb/tb_axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_burst_addr_gen
// Description : Self-checking bench for axi_burst_addr_gen with default
//               parameters (64-bit address, 32-bit data, 8-bit len, 6-bit id).
//               A queue-based model lists the expected beats of each burst
//               from the AXI addressing rules; a compare process checks every
//               offered beat against the head of that queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_burst_addr_gen;

    localparam int MAX_SIZE = $clog2(32 / 8);

    logic        i_clk        = 1'b0;
    logic        i_reset      = 1'b1;
    logic        i_cmd_valid  = 1'b0;
    logic        o_cmd_ready;
    logic [63:0] i_cmd_addr   = '0;
    logic [7:0]  i_cmd_len    = '0;
    logic [2:0]  i_cmd_size   = '0;
    logic [1:0]  i_cmd_burst  = '0;
    logic [5:0]  i_cmd_id     = '0;
    logic        o_beat_valid;
    logic        i_beat_ready = 1'b1;
    logic [63:0] o_beat_addr;
    logic [5:0]  o_beat_id;
    logic [7:0]  o_beat_idx;
    logic        o_beat_last;
    logic        o_err;

    axi_burst_addr_gen dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_cmd_valid  (i_cmd_valid),
        .o_cmd_ready  (o_cmd_ready),
        .i_cmd_addr   (i_cmd_addr),
        .i_cmd_len    (i_cmd_len),
        .i_cmd_size   (i_cmd_size),
        .i_cmd_burst  (i_cmd_burst),
        .i_cmd_id     (i_cmd_id),
        .o_beat_valid (o_beat_valid),
        .i_beat_ready (i_beat_ready),
        .o_beat_addr  (o_beat_addr),
        .o_beat_id    (o_beat_id),
        .o_beat_idx   (o_beat_idx),
        .o_beat_last  (o_beat_last),
        .o_err        (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [63:0] addr;
        int          idx;
        bit          last;
        bit          err;
        logic [5:0]  id;
    } beat_t;

    beat_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    t_first = 0;
    int    t_last  = 0;
    bit    started = 0;
    bit    bubble_chk = 0;

    always @(posedge i_clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected beats of one burst, straight from the addressing rules.
    task automatic build(input logic [63:0] a, input int len, input int size,
                         input int burst, input logic [5:0] id);
        int          sz;
        int          b;
        bit          err;
        logic [63:0] bytes;
        logic [63:0] al;
        logic [63:0] win;
        logic [63:0] base;
        beat_t       e;
        sz  = size;
        b   = burst;
        err = 0;
        if (sz > MAX_SIZE) begin sz = MAX_SIZE; err = 1; end
        if (b == 3) begin b = 1; err = 1; end
        if (b == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) begin b = 1; err = 1; end
        bytes = 64'd1 << sz;
        al    = a & ~(bytes - 64'd1);
`ifdef AXI_BURST_4K_CHECK_EN
        if (b == 1 && (((al + 64'(len + 1) * bytes - 64'd1) >> 12) != (a >> 12))) err = 1;
`endif
        win  = 64'(len + 1) * bytes;
        base = al - (al % win);
        for (int i = 0; i <= len; i++) begin
            if (i == 0 || b == 0) e.addr = a;
            else if (b == 2)      e.addr = base + ((al - base + 64'(i) * bytes) % win);
            else                  e.addr = al + 64'(i) * bytes;
            e.idx  = i;
            e.last = (i == len);
            e.err  = err;
            e.id   = id;
            exp_q.push_back(e);
        end
    endtask

    // Compare process: every offered beat must match the model's next beat.
    always @(negedge i_clk) begin
        if (i_reset) begin
            started    = 0;
            bubble_chk = 0;
        end else begin
            if (bubble_chk) begin
                check("ready_after_last", o_cmd_ready, 1);
                bubble_chk = 0;
            end
            check("ready_vs_valid", o_cmd_ready, !o_beat_valid);
            if (o_beat_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got addr 0x%0h, want no beat", o_beat_addr);
                end else begin
                    check("beat_addr", o_beat_addr, exp_q[0].addr);
                    check("beat_idx",  o_beat_idx,  64'(exp_q[0].idx));
                    check("beat_last", o_beat_last, exp_q[0].last);
                    check("beat_err",  o_err,       exp_q[0].err);
                    check("beat_id",   o_beat_id,   exp_q[0].id);
                    if (exp_q[0].idx == 0 && !started) begin
                        started = 1;
                        t_first = cyc;
                    end
                    if (i_beat_ready) begin
                        if (exp_q[0].last) begin
                            t_last     = cyc;
                            started    = 0;
                            bubble_chk = 1;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_cmd(input logic [63:0] a, input int len, input int size,
                            input int burst, input logic [5:0] id, input bit toggle);
        bit ok;
        ok = 0;
        @(posedge i_clk) #1;
        i_cmd_valid  = 1'b1;
        i_cmd_addr   = a;
        i_cmd_len    = 8'(len);
        i_cmd_size   = 3'(size);
        i_cmd_burst  = 2'(burst);
        i_cmd_id     = id;
        i_beat_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_cmd_ready) begin ok = 1; break; end
        end
        @(posedge i_clk) #1;
        i_cmd_valid  = 1'b0;
        i_beat_ready = toggle ? 1'b0 : 1'b1;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL cmd_accept: got no o_cmd_ready in 20 cycles, want ready");
        end
    endtask

    task automatic drain(input bit toggle);
        bit done;
        done = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge i_clk) #1;
            if (exp_q.size() == 0) begin done = 1; break; end
            if (toggle) i_beat_ready = ~i_beat_ready;
        end
        i_beat_ready = 1'b1;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d beats pending after 200 cycles, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [63:0] a, input int len, input int size,
                       input int burst, input logic [5:0] id, input bit toggle);
        send_cmd(a, len, size, burst, id, toggle);
        drain(toggle);
    endtask

    initial begin
        bit seen;

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_cmd_ready", o_cmd_ready, 0);
        check("rst_valid",     o_beat_valid, 0);
        check("rst_last",      o_beat_last, 0);
        check("rst_err",       o_err, 0);
        check("rst_idx",       o_beat_idx, 0);
        check("rst_addr",      o_beat_addr, 0);
        check("rst_id",        o_beat_id, 0);
        @(posedge i_clk) #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        check("ready_after_rst", o_cmd_ready, 1);

        // INCR, unaligned start
        build(64'h1002, 3, 2, 1, 6'd5);
        check("pin_incr_a0", exp_q[0].addr, 64'h1002);
        check("pin_incr_a1", exp_q[1].addr, 64'h1004);
        check("pin_incr_a3", exp_q[3].addr, 64'h100C);
        check("pin_incr_last", exp_q[3].last, 1);
        check("pin_incr_err", exp_q[3].err, 0);
        run(64'h1002, 3, 2, 1, 6'd5, 0);

        // WRAP within a 16-byte window
        build(64'h38, 3, 2, 2, 6'd9);
        check("pin_wrap_a1", exp_q[1].addr, 64'h3C);
        check("pin_wrap_a2", exp_q[2].addr, 64'h30);
        check("pin_wrap_a3", exp_q[3].addr, 64'h34);
        run(64'h38, 3, 2, 2, 6'd9, 0);

        // FIXED with ready toggling: 10 cycles first valid to last handshake
        build(64'h40, 4, 2, 0, 6'd33);
        check("pin_fixed_a4", exp_q[4].addr, 64'h40);
        run(64'h40, 4, 2, 0, 6'd33, 1);
        check("fixed_cycles", 64'(t_last - t_first + 1), 64'd10);

        // WRAP with illegal len -> INCR + err
        build(64'h100, 2, 2, 2, 6'd1);
        check("pin_badwrap_a2", exp_q[2].addr, 64'h108);
        check("pin_badwrap_err", exp_q[0].err, 1);
        run(64'h100, 2, 2, 2, 6'd1, 0);

        // Reserved burst -> INCR + err
        build(64'h80, 2, 1, 3, 6'd2);
        check("pin_rsvd_a2", exp_q[2].addr, 64'h84);
        run(64'h80, 2, 1, 3, 6'd2, 0);

        // Oversized beat clamps to bus width
        build(64'h200, 2, 3, 1, 6'd3);
        check("pin_size_a1", exp_q[1].addr, 64'h204);
        check("pin_size_err", exp_q[1].err, 1);
        run(64'h200, 2, 3, 1, 6'd3, 0);

        // INCR ending in the next 4 KiB page
        build(64'hFFC, 1, 2, 1, 6'd4);
        check("pin_4k_a1", exp_q[1].addr, 64'h1000);
`ifdef AXI_BURST_4K_CHECK_EN
        check("pin_4k_err", exp_q[0].err, 1);
`else
        check("pin_4k_err", exp_q[0].err, 0);
`endif
        run(64'hFFC, 1, 2, 1, 6'd4, 0);

        // Address space wrap-around
        build(64'hFFFF_FFFF_FFFF_FFFC, 1, 2, 1, 6'd7);
        check("pin_top_a1", exp_q[1].addr, 64'h0);
        run(64'hFFFF_FFFF_FFFF_FFFC, 1, 2, 1, 6'd7, 0);

        // len=0 single beat
        build(64'h777, 0, 0, 1, 6'd11);
        check("pin_len0_last", exp_q[0].last, 1);
        run(64'h777, 0, 0, 1, 6'd11, 0);

        // Unaligned WRAP, 8 halfword beats
        build(64'h13, 7, 1, 2, 6'd12);
        check("pin_wrap8_a1", exp_q[1].addr, 64'h14);
        check("pin_wrap8_a7", exp_q[7].addr, 64'h10);
        run(64'h13, 7, 1, 2, 6'd12, 0);

        // Reset during beat 2 of a len-7 burst
        build(64'h500, 7, 2, 1, 6'd20);
        send_cmd(64'h500, 7, 2, 1, 6'd20, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_beat_valid && o_beat_idx == 8'd1) begin seen = 1; break; end
        end
        check("mid_beat1_seen", seen, 1);
        @(posedge i_clk) #1;
        i_reset = 1'b1;
        exp_q.delete();
        @(negedge i_clk);
        check("mid_rst_valid", o_beat_valid, 0);
        check("mid_rst_last",  o_beat_last, 0);
        check("mid_rst_ready", o_cmd_ready, 0);
        @(posedge i_clk) #1;
        @(posedge i_clk) #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        check("mid_ready_after", o_cmd_ready, 1);
        check("mid_valid_after", o_beat_valid, 0);

        // Normal burst after the abandoned one
        build(64'h2000, 2, 2, 1, 6'd21);
        run(64'h2000, 2, 2, 1, 6'd21, 0);

        repeat (2) @(posedge i_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_axi_burst_addr_gen
`default_nettype wire
